// File: rtl/pmp_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmp_access_arbiter
// Description : Shares one combinational PMP checker between the fetch port
//               and the load/store port. Each access is latched, checked in a
//               dedicated cycle and answered with a one-cycle ok/fault pulse.
//               A denied access leaves a fault record (cause, tval) pending
//               for clint until acknowledged, and stalls the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int PLEN   = 34
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_ok_o,
  output logic              if_fault_o,
  // load/store port
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_ok_o,
  output logic              ls_fault_o,
  // PMP checker
  output logic              pmp_req_o,
  output logic [PLEN-1:0]   pmp_addr_o,
  output logic [1:0]        pmp_size_o,
  output logic              pmp_r_o,
  output logic              pmp_w_o,
  output logic              pmp_x_o,
  input  logic              pmp_exception_i,
  // fault record towards clint
  output logic              fault_o,
  output logic [3:0]        fault_cause_o,
  output logic [ADDR_W-1:0] fault_tval_o,
  input  logic              fault_ack_i,
  // stall towards ctrl
  output logic              hold_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  // Access kind of the latched request; fetch is 0 so a reset latch is benign.
  localparam logic [1:0] ACC_FETCH = 2'd0;
  localparam logic [1:0] ACC_LOAD  = 2'd1;
  localparam logic [1:0] ACC_STORE = 2'd2;

  localparam logic [3:0] CAUSE_FETCH = 4'd1;
  localparam logic [3:0] CAUSE_LOAD  = 4'd5;
  localparam logic [3:0] CAUSE_STORE = 4'd7;

  // last_grant encoding: 0 = fetch port, 1 = load/store port
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        acc_q, acc_d;
  logic              last_grant_q, last_grant_d;
  logic              if_gnt_q, if_gnt_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              if_ok_q, if_ok_d;
  logic              ls_ok_q, ls_ok_d;
  logic              if_fault_q, if_fault_d;
  logic              ls_fault_q, ls_fault_d;
  logic              fault_q, fault_d;
  logic [3:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] tval_q, tval_d;

  logic              w_pick_ls;
  logic              w_owner_ls;
  logic [3:0]        w_cause;
  logic              w_in_check;
  logic [PLEN-1:0]   w_pmp_addr;

  // Cause code and owning port of the access currently latched.
  always_comb begin
    w_owner_ls = (acc_q != ACC_FETCH);
    case (acc_q)
      ACC_LOAD:  w_cause = CAUSE_LOAD;
      ACC_STORE: w_cause = CAUSE_STORE;
      default:   w_cause = CAUSE_FETCH;
    endcase
  end

  // Arbitration, check sequencing and fault bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    last_grant_d = last_grant_q;
    if_gnt_d     = 1'b0;
    ls_gnt_d     = 1'b0;
    if_ok_d      = 1'b0;
    ls_ok_d      = 1'b0;
    if_fault_d   = 1'b0;
    ls_fault_d   = 1'b0;
    fault_d      = fault_q;
    cause_d      = cause_q;
    tval_d       = tval_q;
    // On a tie the port that did not win last time gets the checker.
    w_pick_ls    = ls_req_i & (~if_req_i | (last_grant_q == GRANT_IF));

    case (state_q)
      ST_IDLE: begin
        if (if_req_i | ls_req_i) begin
          state_d = ST_CHECK;
          if (w_pick_ls) begin
            last_grant_d = GRANT_LS;
            ls_gnt_d     = 1'b1;
            addr_d       = ls_addr_i;
            acc_d        = ls_we_i ? ACC_STORE : ACC_LOAD;
          end else begin
            last_grant_d = GRANT_IF;
            if_gnt_d     = 1'b1;
            addr_d       = if_addr_i;
            acc_d        = ACC_FETCH;
          end
        end
      end
      ST_CHECK: begin
        if (pmp_exception_i) begin
          state_d    = ST_FAULT;
          fault_d    = 1'b1;
          cause_d    = w_cause;
          tval_d     = addr_q;
          ls_fault_d = w_owner_ls;
          if_fault_d = ~w_owner_ls;
        end else begin
          state_d = ST_IDLE;
          ls_ok_d = w_owner_ls;
          if_ok_d = ~w_owner_ls;
        end
      end
      ST_FAULT: begin
        if (fault_ack_i) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      acc_q        <= ACC_FETCH;
      last_grant_q <= GRANT_IF;
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      if_ok_q      <= 1'b0;
      ls_ok_q      <= 1'b0;
      if_fault_q   <= 1'b0;
      ls_fault_q   <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= 4'd0;
      tval_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      last_grant_q <= last_grant_d;
      if_gnt_q     <= if_gnt_d;
      ls_gnt_q     <= ls_gnt_d;
      if_ok_q      <= if_ok_d;
      ls_ok_q      <= ls_ok_d;
      if_fault_q   <= if_fault_d;
      ls_fault_q   <= ls_fault_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      tval_q       <= tval_d;
    end
  end

  // Checker drive: only live during CHECK, address zero-extended to PLEN.
  always_comb begin
    w_in_check = (state_q == ST_CHECK);
    w_pmp_addr = '0;
    if (w_in_check) begin
      w_pmp_addr[ADDR_W-1:0] = addr_q;
    end
  end

  assign pmp_req_o     = w_in_check;
  assign pmp_addr_o    = w_pmp_addr;
  assign pmp_size_o    = 2'd3;
  assign pmp_x_o       = w_in_check & (acc_q == ACC_FETCH);
  assign pmp_r_o       = w_in_check & (acc_q == ACC_LOAD);
  assign pmp_w_o       = w_in_check & (acc_q == ACC_STORE);

  assign if_gnt_o      = if_gnt_q;
  assign ls_gnt_o      = ls_gnt_q;
  assign if_ok_o       = if_ok_q;
  assign ls_ok_o       = ls_ok_q;
  assign if_fault_o    = if_fault_q;
  assign ls_fault_o    = ls_fault_q;

  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign fault_tval_o  = tval_q;

  // Stall whenever the checker is busy, a fault is pending, or a request waits.
  assign hold_o = (state_q == ST_CHECK) | (state_q == ST_FAULT) |
                  ((state_q == ST_IDLE) & (if_req_i | ls_req_i));

endmodule
`default_nettype wire

// File: tb/tb_pmp_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmp_access_arbiter
// Description : Self-checking bench for pmp_access_arbiter. A transaction-level
//               model predicts every output each cycle; directed sequences pin
//               the model with hand-computed literals, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmp_access_arbiter;

  localparam int ADDR_W = 32;
  localparam int PLEN   = 34;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              ls_req_i = 1'b0;
  logic              ls_we_i = 1'b0;
  logic [ADDR_W-1:0] ls_addr_i = '0;
  logic              fault_ack_i = 1'b0;
  logic              pmp_exception_i;

  logic              if_gnt_o, if_ok_o, if_fault_o;
  logic              ls_gnt_o, ls_ok_o, ls_fault_o;
  logic              pmp_req_o, pmp_r_o, pmp_w_o, pmp_x_o;
  logic [PLEN-1:0]   pmp_addr_o;
  logic [1:0]        pmp_size_o;
  logic              fault_o;
  logic [3:0]        fault_cause_o;
  logic [ADDR_W-1:0] fault_tval_o;
  logic              hold_o;

  int checks = 0;
  int errors = 0;
  // Checker behaviour: 0 = address-based rule, 1 = always permit, 2 = always deny
  int mode   = 1;

  pmp_access_arbiter #(.ADDR_W(ADDR_W), .PLEN(PLEN)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .if_gnt_o        (if_gnt_o),
    .if_ok_o         (if_ok_o),
    .if_fault_o      (if_fault_o),
    .ls_req_i        (ls_req_i),
    .ls_we_i         (ls_we_i),
    .ls_addr_i       (ls_addr_i),
    .ls_gnt_o        (ls_gnt_o),
    .ls_ok_o         (ls_ok_o),
    .ls_fault_o      (ls_fault_o),
    .pmp_req_o       (pmp_req_o),
    .pmp_addr_o      (pmp_addr_o),
    .pmp_size_o      (pmp_size_o),
    .pmp_r_o         (pmp_r_o),
    .pmp_w_o         (pmp_w_o),
    .pmp_x_o         (pmp_x_o),
    .pmp_exception_i (pmp_exception_i),
    .fault_o         (fault_o),
    .fault_cause_o   (fault_cause_o),
    .fault_tval_o    (fault_tval_o),
    .fault_ack_i     (fault_ack_i),
    .hold_o          (hold_o)
  );

  always #5 clk = ~clk;

  function automatic logic deny(input logic [ADDR_W-1:0] a);
    return (a[3:2] == 2'b11);
  endfunction

  // Stand-in PMP checker, combinational from the DUT's checker outputs.
  assign pmp_exception_i = (mode == 2) ||
                           ((mode == 0) && pmp_req_o && deny(pmp_addr_o[ADDR_W-1:0]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic              ls;     // owner is the load/store port
    logic [3:0]        cause;  // mcause this access would raise (1/5/7)
    logic [ADDR_W-1:0] addr;
  } txn_t;

  bit         m_busy;          // an access owns the checker this cycle
  txn_t       m_txn;
  bit         m_fault;
  logic [3:0] m_cause;
  logic [ADDR_W-1:0] m_tval;
  bit         m_prev_ls;       // last winner was the load/store port
  bit         e_if_ok, e_ls_ok, e_if_fault, e_ls_fault;

  function automatic bit verdict(input logic [ADDR_W-1:0] a);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'b0;
    return deny(a);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_fault = 0; m_cause = 4'd0; m_tval = '0; m_prev_ls = 0;
    m_txn.ls = 0; m_txn.cause = 4'd0; m_txn.addr = '0;
    e_if_ok = 0; e_ls_ok = 0; e_if_fault = 0; e_ls_fault = 0;
  endtask

  task automatic model_step();
    bit take_ls;
    e_if_ok = 0; e_ls_ok = 0; e_if_fault = 0; e_ls_fault = 0;
    if (m_busy) begin
      m_busy = 0;
      if (verdict(m_txn.addr)) begin
        m_fault = 1; m_cause = m_txn.cause; m_tval = m_txn.addr;
        if (m_txn.ls) e_ls_fault = 1; else e_if_fault = 1;
      end else begin
        if (m_txn.ls) e_ls_ok = 1; else e_if_ok = 1;
      end
    end else if (m_fault) begin
      if (fault_ack_i) m_fault = 0;
    end else if (if_req_i || ls_req_i) begin
      take_ls = ls_req_i && !(if_req_i && m_prev_ls);
      m_prev_ls   = take_ls;
      m_busy      = 1;
      m_txn.ls    = take_ls;
      m_txn.addr  = take_ls ? ls_addr_i : if_addr_i;
      m_txn.cause = take_ls ? (ls_we_i ? 4'd7 : 4'd5) : 4'd1;
    end
  endtask

  task automatic compare_all();
    logic [PLEN-1:0] exp_addr;
    exp_addr = m_busy ? {{(PLEN-ADDR_W){1'b0}}, m_txn.addr} : '0;
    check("m.if_gnt",   64'(if_gnt_o),   64'(m_busy && !m_txn.ls));
    check("m.ls_gnt",   64'(ls_gnt_o),   64'(m_busy && m_txn.ls));
    check("m.if_ok",    64'(if_ok_o),    64'(e_if_ok));
    check("m.ls_ok",    64'(ls_ok_o),    64'(e_ls_ok));
    check("m.if_fault", 64'(if_fault_o), 64'(e_if_fault));
    check("m.ls_fault", 64'(ls_fault_o), 64'(e_ls_fault));
    check("m.pmp_req",  64'(pmp_req_o),  64'(m_busy));
    check("m.pmp_addr", 64'(pmp_addr_o), 64'(exp_addr));
    check("m.pmp_size", 64'(pmp_size_o), 64'd3);
    check("m.pmp_x",    64'(pmp_x_o),    64'(m_busy && m_txn.cause == 4'd1));
    check("m.pmp_r",    64'(pmp_r_o),    64'(m_busy && m_txn.cause == 4'd5));
    check("m.pmp_w",    64'(pmp_w_o),    64'(m_busy && m_txn.cause == 4'd7));
    check("m.fault_o",  64'(fault_o),    64'(m_fault));
    check("m.cause",    64'(fault_cause_o), 64'(m_cause));
    check("m.tval",     64'(fault_tval_o),  64'(m_tval));
    check("m.hold",     64'(hold_o),     64'(m_busy || m_fault || if_req_i || ls_req_i));
  endtask

  // Single compare process: advance the model at each edge, check 1 ns later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst.fault_o",  64'(fault_o),    64'd0);
    check("rst.if_gnt",   64'(if_gnt_o),   64'd0);
    check("rst.ls_gnt",   64'(ls_gnt_o),   64'd0);
    check("rst.pmp_req",  64'(pmp_req_o),  64'd0);
    check("rst.pmp_size", 64'(pmp_size_o), 64'd3);
    check("rst.hold",     64'(hold_o),     64'd0);

    // Tie from reset: ls, if, ls, if; responses two cycles after each request.
    mode = 1;
    if_req_i = 1; ls_req_i = 1; ls_we_i = 0;
    if_addr_i = 32'h0000_0100; ls_addr_i = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rr.ls_gnt", 64'(ls_gnt_o), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("rr.if_gnt", 64'(if_gnt_o), (k % 2 == 1) ? 64'd1 : 64'd0);
      cyc();
      check("rr.ls_ok",  64'(ls_ok_o),  (k % 2 == 0) ? 64'd1 : 64'd0);
      check("rr.if_ok",  64'(if_ok_o),  (k % 2 == 1) ? 64'd1 : 64'd0);
    end
    if_req_i = 0; ls_req_i = 0;
    cyc();

    // Store fault: requests ignored while the fault is pending.
    mode = 2;
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h8000_0004;
    cyc();
    check("st.ls_gnt", 64'(ls_gnt_o), 64'd1);
    check("st.pmp_w",  64'(pmp_w_o),  64'd1);
    check("st.pmp_r",  64'(pmp_r_o),  64'd0);
    if_req_i = 1;
    cyc();
    check("st.ls_fault", 64'(ls_fault_o),    64'd1);
    check("st.fault_o",  64'(fault_o),       64'd1);
    check("st.cause",    64'(fault_cause_o), 64'd7);
    check("st.tval",     64'(fault_tval_o),  64'h8000_0004);
    check("st.hold",     64'(hold_o),        64'd1);
    repeat (2) begin
      cyc();
      check("st.no_if_gnt", 64'(if_gnt_o), 64'd0);
      check("st.no_ls_gnt", 64'(ls_gnt_o), 64'd0);
      check("st.held",      64'(fault_o),  64'd1);
    end
    fault_ack_i = 1; if_req_i = 0; ls_req_i = 0; ls_we_i = 0;
    cyc();
    check("st.fault_clr", 64'(fault_o),       64'd0);
    check("st.cause_kept",64'(fault_cause_o), 64'd7);
    fault_ack_i = 0;

    // Fetch fault; an ack while idle beforehand does nothing.
    fault_ack_i = 1;
    cyc();
    check("ff.idle_ack", 64'(fault_o), 64'd0);
    fault_ack_i = 0; if_req_i = 1; if_addr_i = 32'h0000_0200;
    cyc();
    check("ff.if_gnt",   64'(if_gnt_o),   64'd1);
    check("ff.pmp_x",    64'(pmp_x_o),    64'd1);
    check("ff.pmp_addr", 64'(pmp_addr_o), 64'h0_0000_0200);
    if_req_i = 0;
    cyc();
    check("ff.if_fault", 64'(if_fault_o),    64'd1);
    check("ff.cause",    64'(fault_cause_o), 64'd1);
    check("ff.tval",     64'(fault_tval_o),  64'h0000_0200);
    fault_ack_i = 1;
    cyc();
    check("ff.fault_clr", 64'(fault_o), 64'd0);
    fault_ack_i = 0;

    // Reset during CHECK aborts silently.
    mode = 1;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h0000_0040;
    cyc();
    check("ra.ls_gnt", 64'(ls_gnt_o), 64'd1);
    ls_req_i = 0;
    rst = 1;
    #1;
    check("ra.ls_gnt",   64'(ls_gnt_o),   64'd0);
    check("ra.pmp_req",  64'(pmp_req_o),  64'd0);
    check("ra.pmp_r",    64'(pmp_r_o),    64'd0);
    check("ra.pmp_addr", 64'(pmp_addr_o), 64'd0);
    check("ra.cause",    64'(fault_cause_o), 64'd0);
    check("ra.tval",     64'(fault_tval_o),  64'd0);
    check("ra.hold",     64'(hold_o),     64'd0);
    cyc();
    check("ra.no_ok",    64'(ls_ok_o),    64'd0);
    check("ra.no_fault", 64'(ls_fault_o), 64'd0);
    rst = 0;

    // Single load after reset, checker permits.
    ls_req_i = 1; ls_addr_i = 32'h0000_1000;
    cyc();
    check("ld.ls_gnt",   64'(ls_gnt_o),   64'd1);
    check("ld.pmp_r",    64'(pmp_r_o),    64'd1);
    check("ld.pmp_addr", 64'(pmp_addr_o), 64'h0_0000_1000);
    ls_req_i = 0;
    cyc();
    check("ld.ls_ok",    64'(ls_ok_o),    64'd1);
    check("ld.idle",     64'(pmp_req_o),  64'd0);
    check("ld.hold",     64'(hold_o),     64'd0);
    cyc();

    // Back-to-back loads: second grant in cycle 3.
    ls_req_i = 1; ls_addr_i = 32'h0000_1000;
    cyc();
    check("bb.gnt1", 64'(ls_gnt_o), 64'd1);
    cyc();
    check("bb.ok1",  64'(ls_ok_o),  64'd1);
    check("bb.gap",  64'(ls_gnt_o), 64'd0);
    cyc();
    check("bb.gnt2", 64'(ls_gnt_o), 64'd1);
    ls_req_i = 0;
    cyc();
    check("bb.ok2",  64'(ls_ok_o),  64'd1);

    // Random traffic against the model.
    mode = 0;
    repeat (3000) begin
      if_req_i    = ($urandom_range(0, 99) < 45);
      ls_req_i    = ($urandom_range(0, 99) < 45);
      ls_we_i     = 1'($urandom_range(0, 1));
      if_addr_i   = $urandom;
      ls_addr_i   = $urandom;
      fault_ack_i = ($urandom_range(0, 99) < 30);
      rst         = ($urandom_range(0, 999) < 5);
      cyc();
    end
    rst = 0; if_req_i = 0; ls_req_i = 0; fault_ack_i = 1;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmp_access_arbiter.md
# pmp_access_arbiter

Shares the single combinational PMP checker between the instruction-fetch port and the load/store port of the tinyriscv core. Each access is latched, checked in a dedicated cycle, and answered with a one-cycle ok or fault pulse. On a violation it holds a precise fault record (cause, tval) for clint until clint acknowledges it, and stalls the pipeline through ctrl in the meantime.

## Interface
Parameters:
- ADDR_W, 32, requester address width
- PLEN, 34, PMP checker physical address width; must be ≥ ADDR_W

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch check request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted (one-cycle pulse)
- if_ok_o  out  1  fetch access permitted (one-cycle pulse)
- if_fault_o  out  1  fetch access denied (one-cycle pulse)
- ls_req_i  in  1  load/store check request
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  load/store address
- ls_gnt_o, ls_ok_o, ls_fault_o  out  1 each  as for the fetch port
- pmp_req_o  out  1  checker request
- pmp_addr_o  out  PLEN  {(PLEN-ADDR_W)'b0, latched addr}
- pmp_size_o  out  2  constant 2'd3
- pmp_r_o, pmp_w_o, pmp_x_o  out  1 each  access type
- pmp_exception_i  in  1  checker verdict, combinational from pmp_* outputs
- fault_o  out  1  fault pending (level), to clint
- fault_cause_o  out  4  mcause code: 1 fetch, 5 load, 7 store
- fault_tval_o  out  ADDR_W  faulting address
- fault_ack_i  in  1  clint has taken the fault
- hold_o  out  1  stall request to ctrl

## Operation
- FSM states: IDLE, CHECK, FAULT. Reset state: IDLE.
- Reset values: every output and every internal register is 0. This includes last_grant, which resets to IF.
- IDLE:
  - If any request is present, latch the winner's address and type (fetch, load or store), then go to CHECK.
  - Only ls requesting: grant ls. Only if requesting: grant if.
  - Both requesting: grant the port that was not granted last (round robin via last_grant). Because last_grant resets to IF, the first tie goes to ls.
- CHECK:
  - Drive the checker: pmp_req_o = 1 and pmp_addr_o from the latch.
  - Access-type mapping: fetch → x=1; load → r=1; store → w=1. All other type bits are 0.
  - Sample pmp_exception_i at the clock edge that ends CHECK.
  - pmp_exception_i = 0: pulse the owner's ok, then go to IDLE.
  - pmp_exception_i = 1: pulse the owner's fault, latch fault_cause_o and fault_tval_o, set fault_o, then go to FAULT.
- Outside CHECK, all pmp_* outputs are 0, except pmp_size_o, which stays at 2'd3.
- FAULT:
  - No requests are accepted. fault_o, fault_cause_o and fault_tval_o are held.
  - On fault_ack_i = 1: clear fault_o and go to IDLE. cause and tval keep their values until the next fault.
  - fault_ack_i is ignored in every state other than FAULT.
- *_gnt_o is registered and is high during the CHECK cycle.
- Requesters may change their address after seeing gnt. A requester that keeps req_i high after its response is treated as a new request.
- hold_o = (state == CHECK) | (state == FAULT) | (state == IDLE & (if_req_i | ls_req_i)).
- Reset asserted mid-operation: the FSM returns to IDLE immediately, outputs return to 0, and no response pulse is issued for the aborted access.

## Timing
- Request seen in IDLE at cycle 0 → gnt high in cycle 1 (CHECK) → ok or fault pulse in cycle 2.
- The state in cycle 2 is IDLE (no fault) or FAULT (fault).
- In cycle 2 after an ok, a new request can be accepted in the same cycle. Sustained throughput is therefore one check per 2 cycles.
- fault_o rises in cycle 2 and falls on the cycle after the edge that sampled fault_ack_i = 1.
- Minimum FAULT duration: 1 cycle.
- pmp_exception_i must settle within the CHECK cycle; its path is combinational through the PMP checker.

## Test plan
- Single load to 0x0000_1000 with checker returning 0: cycle 1 has ls_gnt_o = 1, pmp_r_o = 1, pmp_addr_o = 0x0_0000_1000. Cycle 2 has ls_ok_o = 1 and state IDLE.
- Fetch and load both requested out of reset, held high: grant order ls, if, ls, if. Responses arrive in cycles 2, 4, 6, 8.
- Store to 0x8000_0004 with checker returning 1: ls_fault_o pulses in cycle 2. fault_o = 1, fault_cause_o = 7, fault_tval_o = 0x8000_0004, hold_o = 1. Requests on both ports are ignored until fault_ack_i, after which fault_o drops one cycle later.
- Fetch fault at 0x0000_0200: fault_cause_o = 1 and if_fault_o pulses. fault_ack_i asserted while in IDLE beforehand has no effect.
- rst asserted during CHECK: all outputs are 0 immediately. No ok or fault pulse occurs. The next request after reset is handled normally with 2-cycle latency.
- Back-to-back loads with checker returning 0: a new ls_gnt_o appears in cycle 3, while ls_ok_o for the first load is in cycle 2.
